// File: rtl/lc3b_types.sv
// Shared LC-3b types: machine word, cache line, and the memory-port
// arbiter's state and requester encodings.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D
  } arb_state_t;

  typedef enum logic {
    SRC_I,
    SRC_D
  } arb_src_t;

endpackage

// File: rtl/mem_cmd_reg.sv
// Memory command register: holds the address, write data and read/write
// command of the granted request so the memory port stays stable while
// memory works. The load enable captures a new command; the clear enable
// drops only the command bits, leaving address and data as they were.
module mem_cmd_reg #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic              ld_read,
  input  logic              ld_write,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [LINE_W-1:0] ld_wdata,
  output logic              cmd_read,
  output logic              cmd_write,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [LINE_W-1:0] cmd_wdata
);

  logic              read_reg;
  logic              write_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [LINE_W-1:0] wdata_reg;

  // Capture on grant, drop the command on completion, hold otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      read_reg  <= 1'b0;
      write_reg <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else if (load) begin
      read_reg  <= ld_read;
      write_reg <= ld_write;
      addr_reg  <= ld_addr;
      wdata_reg <= ld_wdata;
    end else if (clear) begin
      read_reg  <= 1'b0;
      write_reg <= 1'b0;
    end
  end

  assign cmd_read  = read_reg;
  assign cmd_write = write_reg;
  assign cmd_addr  = addr_reg;
  assign cmd_wdata = wdata_reg;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing the physical-memory port between the I-cache and D-cache
// miss handlers. One request is captured per grant and held on the port
// until memory responds; the response strobe is routed to the granted side.
// Build option ARB_ROUND_ROBIN_EN: on a tie in IDLE, grant the requester
// that was not served last (default build: D always beats I).
module mem_port_arbiter
  import lc3b_types::*;
#(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_resp,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_resp,
  output logic [LINE_W-1:0] d_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic              pmem_resp,
  input  logic [LINE_W-1:0] pmem_rdata,
  output logic              busy
);

  arb_state_t state_reg;
  logic       d_req;
  logic       i_req;
  logic       grant_d;
  logic       grant_i;
  logic       cmd_load;
  logic       cmd_clear;
  logic              ld_read;
  logic              ld_write;
  logic [ADDR_W-1:0] ld_addr;
  logic [LINE_W-1:0] ld_wdata;

`ifdef ARB_ROUND_ROBIN_EN
  arb_src_t last_reg;
`endif

  // Grant decision; requests are only looked at while IDLE.
  always_comb begin
    d_req   = d_read | d_write;
    i_req   = i_read;
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (state_reg == IDLE) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (d_req && i_req) begin
        grant_d = (last_reg == SRC_I);
        grant_i = (last_reg == SRC_D);
      end else begin
        grant_d = d_req;
        grant_i = i_req;
      end
`else
      grant_d = d_req;
      grant_i = i_req & ~d_req;
`endif
    end
  end

  // Command to capture: a D request with both bits set is treated as a write.
  always_comb begin
    cmd_load  = grant_d | grant_i;
    cmd_clear = (state_reg != IDLE) && pmem_resp;
    ld_read   = grant_d ? (d_read & ~d_write) : 1'b1;
    ld_write  = grant_d & d_write;
    ld_addr   = grant_d ? d_addr : i_addr;
    ld_wdata  = grant_d ? d_wdata : pmem_wdata;
  end

  // Grant FSM: IDLE -> SERVE_x on grant, back to IDLE on the memory response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
`ifdef ARB_ROUND_ROBIN_EN
      last_reg  <= SRC_I;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_d) begin
            state_reg <= SERVE_D;
          end else if (grant_i) begin
            state_reg <= SERVE_I;
          end
`ifdef ARB_ROUND_ROBIN_EN
          if (grant_d) begin
            last_reg <= SRC_D;
          end else if (grant_i) begin
            last_reg <= SRC_I;
          end
`endif
        end
        SERVE_I, SERVE_D: begin
          if (pmem_resp) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  mem_cmd_reg #(
    .ADDR_W (ADDR_W),
    .LINE_W (LINE_W)
  ) u_cmd (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (cmd_load),
    .clear     (cmd_clear),
    .ld_read   (ld_read),
    .ld_write  (ld_write),
    .ld_addr   (ld_addr),
    .ld_wdata  (ld_wdata),
    .cmd_read  (pmem_read),
    .cmd_write (pmem_write),
    .cmd_addr  (pmem_addr),
    .cmd_wdata (pmem_wdata)
  );

  // Response strobes are qualified by the granted side; data is shared.
  assign i_resp  = (state_reg == SERVE_I) && pmem_resp;
  assign d_resp  = (state_reg == SERVE_D) && pmem_resp;
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;
  assign busy    = (state_reg != IDLE);

  // Read and writeback together is a requester protocol violation.
  assert property (@(posedge clk) disable iff (!rst_n) !(d_read && d_write));

endmodule
